// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receive front end: conditions the raw PS/2 lines, deserialises
// device-to-host frames, folds E0/F0 prefixes into flags and queues completed
// scan codes in a show-ahead FIFO for the downstream keyboard translation logic.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FIFO_AW        = 3
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       PS2_Clk,
    input  logic       PS2_Data,
    input  logic       rd_i,
    output logic [7:0] code_o,
    output logic       release_o,
    output logic       extended_o,
    output logic       avail_o,
    output logic       overflow_o,
    output logic       frame_err_o
);
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEPTH  = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 ps2_clk_p0, ps2_clk_p1;
    logic                 ps2_dat_p0, ps2_dat_p1;
    logic                 filt_clk;
    logic [FILT_W-1:0]    filt_cnt;
    logic                 fall;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;
    logic                 par_bit;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 tmo;
    logic                 frame_ok, frame_bad;
    logic                 ext_flag, rel_flag;
    logic                 push_vld;
    logic [9:0]           push_data;
    logic                 frame_err;

    logic [9:0]           mem [DEPTH];
    logic [FIFO_AW:0]     wr_ptr, rd_ptr;
    logic                 empty, full, pop, push;
    logic [9:0]           head;

    // Two-flop synchronisers for both asynchronous PS/2 lines
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_p0 <= 1'b0;
            ps2_clk_p1 <= 1'b0;
            ps2_dat_p0 <= 1'b0;
            ps2_dat_p1 <= 1'b0;
        end else begin
            ps2_clk_p0 <= PS2_Clk;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_dat_p0 <= PS2_Data;
            ps2_dat_p1 <= ps2_dat_p0;
        end
    end

    // Glitch filter: accept a new clock level after FILTER_LEN equal samples
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk <= 1'b0;
            filt_cnt <= '0;
        end else if (ps2_clk_p1 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
            filt_clk <= ps2_clk_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // The falling edge is the cycle in which the filtered clock flips 1->0
    assign fall = filt_clk && !ps2_clk_p1 && (filt_cnt == FILT_W'(FILTER_LEN - 1));

    // Frame FSM next state and end-of-frame classification
    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        // An edge clears the counter, so a timeout never coincides with one
        tmo       = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !fall;
        if (tmo) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!ps2_dat_p1) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (ps2_dat_p1 && (^{shreg, par_bit})) frame_ok  = 1'b1;
                    else                                   frame_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control state: FSM, bit counter, timeout counter, prefix flags, push strobe
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            tmo_cnt   <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
            push_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= frame_bad | tmo;
            push_vld  <= 1'b0;
            if (fall || tmo || state == IDLE) tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + 1'b1;
            if (fall && state == IDLE)      bit_cnt <= 3'd0;
            else if (fall && state == DATA) bit_cnt <= bit_cnt + 3'd1;
            if (frame_bad || tmo) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (frame_ok) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else begin
                    push_vld <= 1'b1;
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end
            end
        end
    end

    // Data path: LSB-first shift register, parity capture and entry to push
    always_ff @(posedge clk25) begin
        if (fall && state == DATA)   shreg   <= {ps2_dat_p1, shreg[7:1]};
        if (fall && state == PARITY) par_bit <= ps2_dat_p1;
        if (frame_ok)                push_data <= {ext_flag, rel_flag, shreg};
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = rd_i && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands
    assign push  = push_vld && (!full || pop);

    // FIFO storage write
    always_ff @(posedge clk25) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pop)                       overflow_o <= 1'b0;
            else if (push_vld && full)     overflow_o <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr[FIFO_AW-1:0]];
    assign avail_o     = !empty;
    assign code_o      = empty ? 8'h00 : head[7:0];
    assign release_o   = !empty && head[8];
    assign extended_o  = !empty && head[9];
    assign frame_err_o = frame_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: frame decode, prefixes, framing errors,
// timeout, FIFO overflow, simultaneous push/pop and mid-frame reset.
module tb_ps2_scan_rx;
    localparam int HALF = 20;

    logic       clk25 = 1'b0;
    logic       reset_n;
    logic       PS2_Clk;
    logic       PS2_Data;
    logic       rd_i;
    logic [7:0] code_o;
    logic       release_o, extended_o, avail_o, overflow_o, frame_err_o;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int e0;
    int k;

    ps2_scan_rx dut (
        .clk25       (clk25),
        .reset_n     (reset_n),
        .PS2_Clk     (PS2_Clk),
        .PS2_Data    (PS2_Data),
        .rd_i        (rd_i),
        .code_o      (code_o),
        .release_o   (release_o),
        .extended_o  (extended_o),
        .avail_o     (avail_o),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
    );

    always #20 clk25 = ~clk25;

    // Count the number of cycles frame_err_o is high
    always @(posedge clk25) if (frame_err_o) err_pulses <= err_pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par_flip,
                                               input logic stop);
        return {stop, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    // Drive nbits LSB-first; returns right after the last falling clock edge
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            PS2_Data = bits[i];
            wait_cyc(HALF);
            PS2_Clk = 1'b0;
            if (i != nbits - 1) begin
                wait_cyc(HALF);
                PS2_Clk = 1'b1;
            end
        end
    endtask

    task automatic release_clk;
        wait_cyc(HALF);
        PS2_Clk  = 1'b1;
        PS2_Data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bits(frame_bits(d, 1'b0, 1'b1), 11);
        release_clk();
    endtask

    task automatic pop;
        rd_i = 1'b1;
        @(negedge clk25);
        rd_i = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        PS2_Clk  = 1'b1;
        PS2_Data = 1'b1;
        rd_i     = 1'b0;
        wait_cyc(5);
        check("rst_code",  32'(code_o), 32'h0);
        check("rst_avail", 32'(avail_o), 32'h0);
        check("rst_ovf",   32'(overflow_o), 32'h0);
        check("rst_err",   32'(frame_err_o), 32'h0);
        check("rst_flags", 32'({release_o, extended_o}), 32'h0);
        reset_n = 1'b1;
        wait_cyc(30);

        // Frame 0x1C: 2 sync + 8 filter cycles to the stop edge, push, then avail
        send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 11);
        wait_cyc(10);
        check("1c_avail_early", 32'(avail_o), 32'h0);
        wait_cyc(1);
        check("1c_avail", 32'(avail_o), 32'h1);
        check("1c_code",  32'(code_o), 32'h1C);
        check("1c_rel",   32'(release_o), 32'h0);
        check("1c_ext",   32'(extended_o), 32'h0);
        release_clk();
        pop();
        check("1c_pop_avail", 32'(avail_o), 32'h0);
        check("1c_pop_code",  32'(code_o), 32'h0);

        // Prefix folding
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("pfx1_code", 32'(code_o), 32'h1C);
        check("pfx1_rel",  32'(release_o), 32'h1);
        check("pfx1_ext",  32'(extended_o), 32'h0);
        pop();
        check("pfx2_code", 32'(code_o), 32'h75);
        check("pfx2_rel",  32'(release_o), 32'h1);
        check("pfx2_ext",  32'(extended_o), 32'h1);
        pop();
        check("pfx_empty", 32'(avail_o), 32'h0);

        // Parity error
        e0 = err_pulses;
        send_bits(frame_bits(8'h1C, 1'b1, 1'b1), 11);
        wait_cyc(10);
        check("par_err_hi", 32'(frame_err_o), 32'h1);
        wait_cyc(1);
        check("par_err_lo", 32'(frame_err_o), 32'h0);
        release_clk();
        check("par_err_cycles", 32'(err_pulses - e0), 32'h1);
        check("par_avail", 32'(avail_o), 32'h0);

        // Stop error
        e0 = err_pulses;
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 11);
        wait_cyc(10);
        check("stop_err_hi", 32'(frame_err_o), 32'h1);
        wait_cyc(1);
        check("stop_err_lo", 32'(frame_err_o), 32'h0);
        release_clk();
        check("stop_err_cycles", 32'(err_pulses - e0), 32'h1);
        check("stop_avail", 32'(avail_o), 32'h0);

        // Timeout: start + 4 data bits, then clock held high
        e0 = err_pulses;
        send_bits(11'b000_0000_1101 << 1, 5);
        k = 0;
        while (!frame_err_o && k < 30000) begin
            @(negedge clk25);
            k++;
            if (k == HALF) begin
                PS2_Clk  = 1'b1;
                PS2_Data = 1'b1;
            end
        end
        check("tmo_latency", 32'(k), 32'd25010);
        wait_cyc(5000);
        check("tmo_err_cycles", 32'(err_pulses - e0), 32'h1);
        check("tmo_avail", 32'(avail_o), 32'h0);
        send_frame(8'h29);
        check("tmo_next_code", 32'(code_o), 32'h29);
        check("tmo_next_flags", 32'({release_o, extended_o}), 32'h0);
        pop();

        // Overflow: nine codes, no reads
        for (int d = 1; d <= 9; d++) send_frame(8'(d));
        check("ovf_set", 32'(overflow_o), 32'h1);
        for (int d = 1; d <= 8; d++) begin
            check("ovf_read", 32'(code_o), 32'(d));
            pop();
            if (d == 1) check("ovf_clear", 32'(overflow_o), 32'h0);
        end
        check("ovf_empty", 32'(avail_o), 32'h0);

        // Push while full with a pop in the push cycle
        for (int d = 1; d <= 8; d++) send_frame(8'(d));
        check("full_no_ovf", 32'(overflow_o), 32'h0);
        send_bits(frame_bits(8'h0A, 1'b0, 1'b1), 11);
        wait_cyc(10);
        rd_i = 1'b1;
        wait_cyc(1);
        rd_i = 1'b0;
        check("simul_ovf",  32'(overflow_o), 32'h0);
        check("simul_head", 32'(code_o), 32'h02);
        release_clk();
        for (int d = 2; d <= 8; d++) begin
            check("simul_read", 32'(code_o), 32'(d));
            pop();
        end
        check("simul_last", 32'(code_o), 32'h0A);
        pop();
        check("simul_empty", 32'(avail_o), 32'h0);

        // Reset mid-frame with an entry queued
        send_frame(8'h33);
        check("pre_rst_avail", 32'(avail_o), 32'h1);
        send_bits(frame_bits(8'h5A, 1'b0, 1'b1), 4);
        wait_cyc(HALF);
        e0 = err_pulses;
        reset_n = 1'b0;
        wait_cyc(3);
        check("mid_rst_avail", 32'(avail_o), 32'h0);
        check("mid_rst_code",  32'(code_o), 32'h0);
        check("mid_rst_ovf",   32'(overflow_o), 32'h0);
        PS2_Clk  = 1'b1;
        PS2_Data = 1'b1;
        reset_n  = 1'b1;
        wait_cyc(40);
        check("mid_rst_no_err", 32'(err_pulses - e0), 32'h0);
        check("mid_rst_avail2", 32'(avail_o), 32'h0);
        send_frame(8'h5A);
        check("post_rst_code", 32'(code_o), 32'h5A);
        check("post_rst_flags", 32'({release_o, extended_o}), 32'h0);
        pop();
        check("post_rst_empty", 32'(avail_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
- PS/2 keyboard receive front end on the 25 MHz domain.
- Deserialises device-to-host frames, checks framing and parity, and folds E0/F0 prefixes into flags on the following code.
- Queues completed scan codes in a small show-ahead FIFO.
- Sits directly upstream of the keyboard ASCII/translation logic that drives kbd_data, kbd_available, stop and AR2 into the CPU core.

Parameters:
FILTER_LEN, 8, consecutive equal samples needed to accept a new PS2_Clk level
TIMEOUT_CYCLES, 25000, clk25 cycles without a falling PS2_Clk edge before a partial frame is aborted (1 ms)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries

Ports:
clk25  in  1  system clock, 25 MHz; the only clock in the block
reset_n  in  1  asynchronous, active-low reset
PS2_Clk  in  1  raw PS/2 clock line (asynchronous)
PS2_Data  in  1  raw PS/2 data line (asynchronous)
rd_i  in  1  pop head entry; single-cycle strobe
code_o  out  8  head scan code; 0 when FIFO empty
release_o  out  1  head entry was preceded by F0
extended_o  out  1  head entry was preceded by E0
avail_o  out  1  FIFO non-empty
overflow_o  out  1  sticky: a code was dropped because the FIFO was full
frame_err_o  out  1  one-cycle pulse on parity error, stop error or timeout

Behaviour:
- Reset: all outputs 0. FSM in IDLE. FIFO empty. Prefix flags, filter, timeout counter and synchronisers cleared. Reset asserted mid-frame discards the partial frame with no frame_err_o.
- Input conditioning:
  - Both PS2 lines pass through 2-flop synchronisers.
  - Filtered clock changes level only after FILTER_LEN consecutive synchronised samples at the new level.
  - An edge is a 1->0 transition of the filtered clock.
  - Data is sampled from the synchronised PS2_Data on the edge cycle.
- FSM (advances on edges only):
  - IDLE: bit 0 -> DATA with bit counter 0. Bit 1 is a bad start; stay in IDLE silently.
  - DATA: shift LSB-first into an 8-bit register. After 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame valid iff stop bit is 1 and data plus parity holds an odd number of ones. Either way -> IDLE.
- Timeout:
  - Counter clears on every edge and runs while state != IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err_o and clears both prefix flags.
- Invalid frame: discarded; frame_err_o pulses on the cycle after the stop edge; prefix flags cleared.
- Valid frame, by code:
  - 0xE0: sets ext flag, nothing pushed.
  - 0xF0: sets rel flag, nothing pushed.
  - Any other code: pushes {ext, rel, code} and clears both flags.
  - The push takes effect on the cycle after the stop edge; avail_o is 1 on the following cycle, i.e. 2 cycles after the stop edge.
- FIFO:
  - Show-ahead: code_o, release_o and extended_o reflect the head entry whenever avail_o=1, and are 0 otherwise.
  - rd_i with avail_o=1 pops in that cycle; the new head or empty state is visible next cycle.
  - rd_i on an empty FIFO is ignored.
  - Push and pop in the same cycle both happen, count unchanged. This includes a push while full, which succeeds because the pop frees a slot.
  - Push while full with no pop: the entry is dropped and overflow_o is set.
  - overflow_o clears on the first accepted pop after it was set.
  - Pointers are FIFO_AW+1 bits with wrap-bit full/empty detection. Count never exceeds 2**FIFO_AW.
- Simultaneous events:
  - A timeout cannot coincide with a stop edge, because any edge clears the counter.
  - A frame_err_o pulse and a pop in the same cycle are independent.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> avail_o=1 two cycles after the stop edge; code_o=0x1C, release_o=0, extended_o=0. rd_i -> avail_o=0, code_o=0.
- Frames F0,1C then E0,F0,75 -> two entries: {0x1C, rel=1, ext=0} then {0x75, rel=1, ext=1}. No entries for the prefix bytes.
- Frame 0x1C with parity 1 -> frame_err_o high exactly 1 cycle, avail_o stays 0. Same again with stop 0 -> same result.
- Start plus 4 data bits, clock held high 1.2 ms -> frame_err_o pulse at 25000 cycles after the last edge. Next frame 0x29 received correctly.
- 9 frames 0x01..0x09 with no reads -> overflow_o=1. Reads return 0x01..0x08 in order; overflow_o=0 after the first read; avail_o=0 after the 8th read.
- FIFO holding 8 entries, rd_i on the stop+1 push cycle of 0x0A -> no overflow; last entry read is 0x0A. Also: reset_n pulsed mid-frame -> all outputs 0, next full frame decoded.
